fifo_drain_stage: RTL

Read-side drain stage sitting directly downstream of the synchronous FIFO. Issues `fifo_rd_en` pops, absorbs the FIFO's one-cycle read latency in a 3-entry circular holding buffer, and presents the words on a valid/ready stream to the next consumer at full rate. Also counts delivered words and flags any FIFO underflow seen on its own reads.

---
 rtl/shared_pkg.sv | 18 +
 rtl/fifo_drain_buf.sv | 66 ++++++
 rtl/fifo_drain_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/shared_pkg.sv
// Shared definitions for the FIFO read-side blocks.
//   DRAIN_BUF_DEPTH    : entries in the drain stage holding buffer
//   DEFAULT_FIFO_WIDTH : data word width shared with the synchronous FIFO
//   drain_ptr_t        : holding buffer pointer type (values 0..2)
//   ptr_next()         : pointer increment with wrap 2 -> 0
package shared_pkg;

    localparam int DRAIN_BUF_DEPTH    = 3;
    localparam int DEFAULT_FIFO_WIDTH = 16;

    typedef logic [1:0] drain_ptr_t;

    // The depth is not a power of two, so the wrap must be explicit.
    function automatic drain_ptr_t ptr_next(input drain_ptr_t p);
        return (p == drain_ptr_t'(DRAIN_BUF_DEPTH - 1)) ? drain_ptr_t'(0) : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_drain_buf.sv
// 3-entry circular holding buffer for the drain stage.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   push         : write push_data at the write pointer (never asserted when full)
//   push_data    : word to store
//   pop          : retire the head entry (only asserted when occ != 0)
//   occ          : number of stored words, 0..3
//   head_data    : word at the read pointer
module fifo_drain_buf
    import shared_pkg::*;
#(
    parameter int W = DEFAULT_FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data
);

    logic [W-1:0] entries [DRAIN_BUF_DEPTH];
    drain_ptr_t   wr_ptr;
    drain_ptr_t   rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DRAIN_BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                for (int i = 0; i < DRAIN_BUF_DEPTH; i++) begin
                    if (wr_ptr == drain_ptr_t'(i)) begin
                        entries[i] <= push_data;
                    end
                end
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Explicit mux keeps the unused pointer code 3 from indexing past the array.
    always_comb begin
        head_data = entries[2];
        case (rd_ptr)
            2'd0:    head_data = entries[0];
            2'd1:    head_data = entries[1];
            default: head_data = entries[2];
        endcase
    end

endmodule

// File: rtl/fifo_drain_stage.sv
// Read-side drain stage for the synchronous FIFO. Pops the FIFO under a
// credit rule, absorbs the FIFO's one-cycle read latency in a 3-entry buffer,
// and streams words to the consumer at full rate.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (shared with the FIFO)
//   drain_en        : permits new FIFO reads
//   fifo_data_out   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty      : FIFO empty flag, current cycle
//   fifo_underflow  : FIFO underflow flag for the previous cycle's read
//   fifo_rd_en      : FIFO pop request
//   m_data, m_valid : output stream word and its valid
//   m_ready         : consumer accepts the word this cycle
//   pop_count       : words delivered downstream, wraps modulo 2^CNT_W
//   err_underflow   : sticky, set when one of our reads underflowed
//
// Stream handshake: a word transfers in any cycle where m_valid and m_ready are
// both high. m_valid never depends on m_ready, and while m_valid is high and
// m_ready low, m_data holds steady until the transfer.
module fifo_drain_stage
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      pop_count,
    output logic                  err_underflow
);

    logic       inflight;
    logic [1:0] occ;
    logic [2:0] credit_used;
    logic       push;
    logic       pop;

    // A read is only issued if there is guaranteed room for its data, counting
    // the word already on its way back. Only registered state and FIFO flags
    // feed this, so there is no path from m_ready to fifo_rd_en.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en  = rst_n & drain_en & ~fifo_empty
                         & (credit_used < 3'(DRAIN_BUF_DEPTH));

    // Data returning from an underflowed read is garbage and is dropped.
    assign push = inflight & ~fifo_underflow;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    fifo_drain_buf #(
        .W (FIFO_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            pop_count     <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                pop_count <= pop_count + 1'b1;
            end
            if (inflight && fifo_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
